// File: rtl/mem_if_multibeat.sv
// mem_if_multibeat
//   Serialises one CPU load/store of 1..DW/MW beats into consecutive MW-wide
//   SRAM accesses. Load data is assembled beat by beat and sign- or
//   zero-extended on completion. Each beat has a timeout, and an illegal size
//   is reported as an error without touching memory.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; ready only while idle
//   req_we/size/signed     store flag, beats = 1<<size, load extension mode
//   req_addr/req_wdata     address of beat 0, store data (beat k = slice k)
//   resp_done/resp_err     one-cycle completion pulse and its error flag
//   resp_rdata             load result, held until the next acceptance
//   mem_we/mem_re          level strobes, held until mem_resp
//   mem_addr/mem_wdata     beat address and write data
//   mem_rdata/mem_resp     beat read data and beat-complete indication
module mem_if_multibeat #(
  parameter int DW      = 16,
  parameter int MW      = 8,
  parameter int AW      = 14,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_done,
  output logic          resp_err,
  output logic [DW-1:0] resp_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [MW-1:0] mem_wdata,
  input  logic [MW-1:0] mem_rdata,
  input  logic          mem_resp
);

  localparam int MAXB = DW / MW;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  // Timeout counter only has to hold 0..TIMEOUT-1.
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            we_r;
  logic [1:0]      size_r;
  logic            signed_r;
  logic [AW-1:0]   addr_r;
  logic [DW-1:0]   wdata_r;
  logic [BW-1:0]   beat_r;
  logic [TW-1:0]   tmo_r;
  logic            err_r;
  logic [DW-1:0]   rdata_r;

  logic            last_s;
  logic            tmo_hit_s;
  logic [AW-1:0]   beat_addr_s;
  logic [DW-1:0]   merged_s;

  // True when the requested beat count fits in the CPU data width.
  function automatic logic size_ok(input logic [1:0] size);
    return ((32'd1 << size) <= 32'(MAXB));
  endfunction

  // Replicates bit[beats*MW-1] (signed) or zero above the loaded beats.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] data,
                                                input logic [1:0]    size,
                                                input logic          sgn);
    logic [DW-1:0] res;
    int            nbits;
    logic          fill;
    nbits = MW << size;
    fill  = sgn & data[nbits-1];
    for (int i = 0; i < DW; i++) begin
      res[i] = (i >= nbits) ? fill : data[i];
    end
    return res;
  endfunction

  assign last_s      = (32'(beat_r) == ((32'd1 << size_r) - 32'd1));
  assign tmo_hit_s   = (tmo_r == TW'(TIMEOUT - 1));
  // Address wraps naturally at AW bits.
  assign beat_addr_s = addr_r + AW'(beat_r);
  assign resp_rdata  = rdata_r;

  // Load data with the arriving beat merged into its slot.
  always_comb begin
    merged_s = rdata_r;
    merged_s[beat_r*MW +: MW] = mem_rdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = size_ok(req_size) ? ST_STROBE : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STROBE: begin
        if (mem_resp) begin
          state_s = last_s ? ST_DONE : ST_GAP;
        end else if (tmo_hit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_STROBE;
        end
      end
      ST_GAP:  state_s = ST_STROBE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and latched request.
  always_comb begin
    req_ready = 1'b0;
    resp_done = 1'b0;
    resp_err  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_r)
      ST_IDLE: req_ready = 1'b1;
      ST_STROBE: begin
        mem_we    = we_r;
        mem_re    = ~we_r;
        mem_addr  = beat_addr_s;
        mem_wdata = wdata_r[beat_r*MW +: MW];
      end
      ST_GAP: req_ready = 1'b0;
      ST_DONE: begin
        resp_done = 1'b1;
        resp_err  = err_r;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Request latch, beat/timeout counters and load-data assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r     <= 1'b0;
      size_r   <= 2'd0;
      signed_r <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      beat_r   <= '0;
      tmo_r    <= '0;
      err_r    <= 1'b0;
      rdata_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r     <= req_we;
            size_r   <= req_size;
            signed_r <= req_signed;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            beat_r   <= '0;
            tmo_r    <= '0;
            err_r    <= ~size_ok(req_size);
            rdata_r  <= '0;
          end
        end
        ST_STROBE: begin
          if (mem_resp) begin
            tmo_r <= '0;
            if (!we_r) begin
              // Extension is folded into the final beat so DONE sees the result.
              rdata_r <= last_s ? extend_load(merged_s, size_r, signed_r) : merged_s;
            end
            if (!last_s) begin
              beat_r <= beat_r + BW'(1);
            end
          end else if (tmo_hit_s) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_GAP:  tmo_r <= '0;
        ST_DONE: err_r <= err_r;
        default: tmo_r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_if_multibeat.sv
module tb_mem_if_multibeat;
  localparam int DW = 16, MW = 8, AW = 14, TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_done, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] mem_rdata = 8'h00;
  logic          mem_resp  = 1'b0;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          mem_clr;
  logic          force_noresp;

  int            total = 0;
  int            bad   = 0;
  logic [DW:0]   exp_q [$];

  always #5 clk = ~clk;

  mem_if_multibeat #(.DW(DW), .MW(MW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // SRAM model: answers one cycle after a strobe is seen, needs a low cycle to re-arm.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
      mem_resp <= 1'b0;
    end else if ((mem_re || mem_we) && !mem_resp && !force_noresp) begin
      mem_resp  <= 1'b1;
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end else begin
      mem_resp <= 1'b0;
    end
  end

  // Scoreboard monitor: pops one expected response per done pulse.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset) begin
      if (mem_re || mem_we) begin
        total++;
        if (mem_re && mem_we) begin
          bad++;
          $display("FAIL strobe_excl: mem_re=%b mem_we=%b required not both high", mem_re, mem_we);
        end
      end
      if (resp_done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: err=%b rdata=%h required no done", resp_err, resp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({resp_err, resp_rdata} !== e) begin
            bad++;
            $display("FAIL resp: err=%b rdata=%h required err=%b rdata=%h",
                     resp_err, resp_rdata, e[DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Issues one request, pushes its expected response and measures latency/strobes.
  task automatic xfer(input string name, input logic we, input logic [1:0] size,
                      input logic sgn, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [DW-1:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_re, input int exp_we);
    int lat, nre, nwe;
    bit seen;
    @(negedge clk);
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nre = 0; nwe = 0; seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_re) nre++;
      if (mem_we) nwe++;
      if (resp_done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_wait: no resp_done within 100 cycles, required latency %0d", name, exp_lat);
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    check({name, "_re_cycles"}, 32'(nre), 32'(exp_re));
    check({name, "_we_cycles"}, 32'(nwe), 32'(exp_we));
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1; force_noresp = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;

    // Reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done",  32'(resp_done), 32'd0);
    check("rst_err",   32'(resp_err),  32'd0);
    check("rst_rdata", 32'(resp_rdata), 32'd0);
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_re",    32'(mem_re), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);

    // 1: two-beat store, 2+gap+2 strobe cycles then done
    xfer("st16", 1'b1, 2'd1, 1'b0, 14'h000A, 16'h1234, 16'h0000, 1'b0, 6, 0, 4);
    check("mem_0A", 32'(mem[14'h000A]), 32'h34);
    check("mem_0B", 32'(mem[14'h000B]), 32'h12);

    // 2: two-beat load back
    xfer("ld16", 1'b0, 2'd1, 1'b0, 14'h000A, 16'h0000, 16'h1234, 1'b0, 6, 4, 0);

    // 3: single-beat store (upper byte ignored), signed and unsigned loads
    xfer("st8", 1'b1, 2'd0, 1'b0, 14'h0020, 16'hAA85, 16'h0000, 1'b0, 3, 0, 2);
    check("mem_20", 32'(mem[14'h0020]), 32'h85);
    check("mem_21", 32'(mem[14'h0021]), 32'h00);
    xfer("ld8s", 1'b0, 2'd0, 1'b1, 14'h0020, 16'h0000, 16'hFF85, 1'b0, 3, 2, 0);
    xfer("ld8u", 1'b0, 2'd0, 1'b0, 14'h0020, 16'h0000, 16'h0085, 1'b0, 3, 2, 0);

    // 4: illegal size, no strobes, rdata cleared
    xfer("badsz", 1'b0, 2'd2, 1'b0, 14'h0020, 16'h0000, 16'h0000, 1'b1, 1, 0, 0);

    // 5: no memory response -> 15 strobe cycles then error
    force_noresp = 1'b1;
    xfer("tmo", 1'b0, 2'd0, 1'b1, 14'h0020, 16'h0000, 16'h0000, 1'b1, 16, 15, 0);
    force_noresp = 1'b0;

    // 6: address wrap across top of memory
    xfer("stwrap", 1'b1, 2'd1, 1'b0, 14'h3FFF, 16'hBEEF, 16'h0000, 1'b0, 6, 0, 4);
    check("mem_3FFF", 32'(mem[14'h3FFF]), 32'hEF);
    check("mem_0000", 32'(mem[14'h0000]), 32'hBE);
    xfer("ldwrap", 1'b0, 2'd1, 1'b1, 14'h3FFF, 16'h0000, 16'hBEEF, 1'b0, 6, 4, 0);

    // 6: reset during STROBE of a load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 14'h000A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst_strobe", 32'(mem_re), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_re",    32'(mem_re), 32'd0);
    check("midrst_we",    32'(mem_we), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_done",  32'(resp_done), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Recovery after reset
    xfer("ld_after", 1'b0, 2'd1, 1'b0, 14'h000A, 16'h0000, 16'h1234, 1'b0, 6, 4, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
